// File: rtl/cmp_pkg.sv
// Shared types and constants for the LSB-first bit-serial magnitude comparator.
//   cmp_state_t : controller states (IDLE, SHIFT, DONE)
//   cmp_res_t   : packed {gt, eq, lt} verdict
//   CMP_RES_EQ  : verdict loaded at the start of a comparison
//   CMP_RES_CLR : all-zero verdict held after reset
//   cnt_w()     : width of the beat counter, max(1, clog2(width))
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_EQ  = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
  localparam cmp_res_t CMP_RES_CLR = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_w(input int width);
    cnt_w = (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/cmp_lsb_step.sv
// One LSB-first comparison step: folds the current bit pair into the running
// verdict. A later (more significant) differing bit always overrides the
// earlier verdict; equal bits leave it unchanged.
// Ports:
//   a_bit, b_bit : current operand bits
//   prev         : verdict so far
//   is_msb       : current pair is the sign/most significant bit
//   next         : updated verdict
// Build option: CMP_SERIAL_SIGNED_EN makes the MSB a two's-complement sign
// bit, which inverts the gt/lt sense on that beat only.
import cmp_pkg::*;

module cmp_lsb_step (
  input  logic     a_bit,
  input  logic     b_bit,
  input  cmp_res_t prev,
  input  logic     is_msb,
  output cmp_res_t next
);

`ifdef CMP_SERIAL_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  logic flip_s;

  // On a signed sign bit, a set bit means the smaller operand.
  assign flip_s = SIGNED_EN & is_msb;

  // Verdict update for one bit pair.
  always_comb begin
    next = prev;
    if (a_bit != b_bit) begin
      if (flip_s) begin
        next.gt = ~a_bit & b_bit;
        next.lt = a_bit & ~b_bit;
      end else begin
        next.gt = a_bit & ~b_bit;
        next.lt = ~a_bit & b_bit;
      end
      next.eq = 1'b0;
    end else begin
      next = prev;
    end
  end

endmodule

// File: rtl/cmp_serial_lsb.sv
// Bit-serial magnitude comparator, operands streamed LSB first.
// After WIDTH accepted beats the result is held with res_valid=1 until the
// next start or reset.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : begin a comparison (honoured in IDLE/DONE only)
//   in_valid/in_ready: bit-pair handshake; in_ready=1 only in SHIFT
//   a_bit, b_bit     : operand bits, LSB first
//   busy             : comparison in progress (SHIFT)
//   res_valid        : gt/eq/lt hold the final result (DONE)
//   gt, eq, lt       : verdict; partial during SHIFT, one-hot in DONE
// Build option: CMP_SERIAL_SIGNED_EN selects two's-complement operands.
import cmp_pkg::*;

module cmp_serial_lsb #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic res_valid,
  output logic gt,
  output logic eq,
  output logic lt
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  cmp_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  cmp_res_t      res_q, res_d;
  cmp_res_t      step_res_s;
  logic          is_msb_s;

  assign is_msb_s = (count_q == LAST);

  cmp_lsb_step u_step (
    .a_bit  (a_bit),
    .b_bit  (b_bit),
    .prev   (res_q),
    .is_msb (is_msb_s),
    .next   (step_res_s)
  );

  // Next-state, counter and verdict update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        // in_valid is ignored here, even in the cycle start is sampled.
        if (start) begin
          state_d = SHIFT;
          count_d = '0;
          res_d   = CMP_RES_EQ;
        end else begin
          state_d = state_q;
        end
      end
      SHIFT: begin
        // start is ignored while shifting; in_ready is implicitly 1 here.
        if (in_valid) begin
          res_d   = step_res_s;
          count_d = count_q + CW'(1);
          if (is_msb_s) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        res_d   = CMP_RES_CLR;
      end
    endcase
  end

  // State, counter and verdict registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      res_q   <= CMP_RES_CLR;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      res_q   <= res_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign in_ready  = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign res_valid = (state_q == DONE);
  assign gt        = res_q.gt;
  assign eq        = res_q.eq;
  assign lt        = res_q.lt;

endmodule
